program_loader: RTL and testbench
=================================

Name: program_loader

Overview:
- Writer side of the instruction memory: receives a byte stream from a host link (UART receiver or debug port) and assembles 32-bit instruction words.
- Writes each word into a RAM-based program memory, starting at byte address 0.
- Holds the CPU off the memory (CpuHold) while loading, then pulses Done so the core can restart from PC=0.
- Sits between the host-link receiver and the program memory write port; the memory keeps its combinational read port for fetch.

Parameters:
- MEMORY_DEPTH, 32, number of 32-bit words in program memory.
- DATA_WIDTH, 32, instruction/word width. Fixed at 32: 4 bytes per word.
- LEN_WIDTH, 6, width of WordCount. Must hold MEMORY_DEPTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request to begin a load. Sampled only in IDLE.
- Abort  input  1  cancel an in-progress load.
- WordCount  input  LEN_WIDTH  number of words to load, sampled with Start.
- ByteIn  input  8  incoming byte.
- ByteValid  input  1  ByteIn valid this cycle.
- ByteReady  output  1  loader accepts a byte this cycle.
- MemWrite  output  1  program memory write enable.
- MemAddress  output  DATA_WIDTH  byte address (word_index*4; low 2 bits always 0).
- MemWriteData  output  DATA_WIDTH  assembled word.
- CpuHold  output  1  CPU must stall/hold PC while 1.
- Busy  output  1  load in progress.
- Done  output  1  one-cycle pulse on successful completion.
- Error  output  1  sticky error flag, cleared by the next accepted Start.

Behaviour:
- Reset (async, reset=0): state=IDLE; byte_cnt=0, word_idx=0, assembly reg=0. All outputs 0: ByteReady, MemWrite, MemAddress, MemWriteData, CpuHold, Busy, Done, Error.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - ByteReady=0, CpuHold=0, Busy=0.
  - Start=1 with 1<=WordCount<=MEMORY_DEPTH: latch length, clear Error, byte_cnt=0, word_idx=0, go to LOAD.
  - Start=1 with WordCount=0 or WordCount>MEMORY_DEPTH: set Error=1, stay in IDLE.
- LOAD:
  - ByteReady=1, CpuHold=1, Busy=1.
  - A byte transfers when ByteValid&ByteReady.
  - Big-endian assembly: first byte of a word goes to [31:24], fourth byte to [7:0]. Implement as a shift-left by 8 with ByteIn in the low byte.
  - byte_cnt increments 0..3. When the 4th byte transfers, byte_cnt wraps to 0 and the state goes to WRITE.
  - Bytes may arrive with any gaps; ByteValid=0 holds all state.
- WRITE (exactly 1 cycle):
  - MemWrite=1, MemAddress=word_idx<<2, MemWriteData=assembled word.
  - ByteReady=0, so bytes presented this cycle are not consumed.
  - If word_idx==length-1, go to DONE; else word_idx++ and go to LOAD.
- DONE (1 cycle): Done=1, CpuHold=1, Busy=1. Next cycle go to IDLE, where CpuHold=0.
- Latency: a word is written 1 cycle after its 4th byte is accepted. Done is 1 cycle after the last write. CpuHold falls 2 cycles after the last write.
- Timing of MemAddress/MemWriteData: registered, valid only while MemWrite=1. They keep their last values otherwise.
- Abort:
  - Abort=1 in LOAD or WRITE: the WRITE cycle in progress still completes its MemWrite. The next state is then IDLE with Error=1, partial word discarded, Done never pulses.
  - Abort in IDLE or DONE is ignored.
  - Abort and Start together in IDLE: Start wins.
- Start while Busy: ignored. Length and counters are unaffected.
- Reset mid-operation: immediate return to the reset values. The memory contents already written are unchanged.
- No address wrap: the length check guarantees word_idx<MEMORY_DEPTH.

Test Plan:
- Single-word load: Start with WordCount=1, then bytes 0x20,0x08,0x00,0x05 back-to-back -> one MemWrite with MemAddress=0x0, MemWriteData=0x20080005; Done 1 cycle later; CpuHold=0 the cycle after.
- Multi-word with gaps: WordCount=3, 12 bytes with random ByteValid gaps -> writes at 0x0, 0x4, 0x8 with the correct big-endian words; exactly 3 MemWrite pulses; Done once.
- Bad length: Start with WordCount=0 -> Error=1, Busy stays 0. Then Start with WordCount=33 (depth 32) -> Error=1. Then Start with WordCount=2 -> Error clears.
- Abort mid-word: WordCount=2, 6 bytes, then Abort -> one write at 0x0 only; state IDLE, Error=1, CpuHold=0, Done never asserted.
- Backpressure: hold ByteValid=1 with a new byte every cycle -> ByteReady=0 in each WRITE cycle, no byte lost or duplicated (check against a 16-byte reference sequence for WordCount=4).
- Async reset during load: reset low after 5 bytes of WordCount=4 -> all outputs 0 immediately (without waiting for a clk edge). After release, a fresh Start reloads from address 0.

Source files
------------

// File: rtl/program_loader_if.sv
// Host-link byte stream in, program-memory write port and CPU control out.
interface program_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 6
);
    logic                  Start;
    logic                  Abort;
    logic [LEN_WIDTH-1:0]  WordCount;
    logic [7:0]            ByteIn;
    logic                  ByteValid;
    logic                  ByteReady;
    logic                  MemWrite;
    logic [DATA_WIDTH-1:0] MemAddress;
    logic [DATA_WIDTH-1:0] MemWriteData;
    logic                  CpuHold;
    logic                  Busy;
    logic                  Done;
    logic                  Error;

    modport master (
        output Start, Abort, WordCount, ByteIn, ByteValid,
        input  ByteReady, MemWrite, MemAddress, MemWriteData, CpuHold, Busy, Done, Error
    );

    modport slave (
        input  Start, Abort, WordCount, ByteIn, ByteValid,
        output ByteReady, MemWrite, MemAddress, MemWriteData, CpuHold, Busy, Done, Error
    );
endinterface

// File: rtl/program_loader.sv
// Assembles big-endian 32-bit words from a byte stream and writes them to
// program memory from address 0, holding the CPU off until the load completes.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for Start; CPU runs
// S_LOAD  | accepting bytes of the current word
// S_WRITE | one-cycle memory write of the assembled word
// S_DONE  | one-cycle Done pulse, CPU still held
module program_loader #(
    parameter int MEMORY_DEPTH = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int LEN_WIDTH    = 6
) (
    input  logic              clk,
    input  logic              reset,
    program_loader_if.slave   bus
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

    localparam logic [LEN_WIDTH-1:0] DEPTH_L = LEN_WIDTH'(MEMORY_DEPTH);
    localparam logic [LEN_WIDTH-1:0] ONE_L   = LEN_WIDTH'(1);

    state_t                  state, state_next;
    logic [1:0]              byte_cnt;
    logic [LEN_WIDTH-1:0]    word_idx;
    logic [LEN_WIDTH-1:0]    len;
    logic [DATA_WIDTH-9:0]   assy;
    logic [DATA_WIDTH-1:0]   mem_address;
    logic [DATA_WIDTH-1:0]   mem_data;
    logic                    error;

    logic len_ok, start_ok, start_bad, byte_xfer, word_full, last_word, abort_hit;

    assign len_ok    = (bus.WordCount != '0) && (bus.WordCount <= DEPTH_L);
    assign start_ok  = (state == S_IDLE) && bus.Start && len_ok;
    assign start_bad = (state == S_IDLE) && bus.Start && !len_ok;
    assign abort_hit = bus.Abort && ((state == S_LOAD) || (state == S_WRITE));
    assign byte_xfer = (state == S_LOAD) && bus.ByteValid && !bus.Abort;
    assign word_full = byte_xfer && (byte_cnt == 2'd3);
    assign last_word = (word_idx == len - ONE_L);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next    = state;
        bus.ByteReady = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.CpuHold   = 1'b0;
        bus.Busy      = 1'b0;
        bus.Done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok) state_next = S_LOAD;
            end
            S_LOAD: begin
                bus.ByteReady = 1'b1;
                bus.CpuHold   = 1'b1;
                bus.Busy      = 1'b1;
                if (bus.Abort)      state_next = S_IDLE;
                else if (word_full) state_next = S_WRITE;
            end
            S_WRITE: begin
                // The write completes even when aborted; only the successor changes.
                bus.MemWrite = 1'b1;
                bus.CpuHold  = 1'b1;
                bus.Busy     = 1'b1;
                if (bus.Abort)      state_next = S_IDLE;
                else if (last_word) state_next = S_DONE;
                else                state_next = S_LOAD;
            end
            S_DONE: begin
                bus.Done    = 1'b1;
                bus.CpuHold = 1'b1;
                bus.Busy    = 1'b1;
                state_next  = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_cnt    <= '0;
            word_idx    <= '0;
            len         <= '0;
            assy        <= '0;
            mem_address <= '0;
            mem_data    <= '0;
            error       <= 1'b0;
        end else begin
            if (start_ok) begin
                len      <= bus.WordCount;
                error    <= 1'b0;
                byte_cnt <= '0;
                word_idx <= '0;
                assy     <= '0;
            end
            if (start_bad || abort_hit) error <= 1'b1;
            if (byte_xfer) begin
                assy     <= {assy[DATA_WIDTH-17:0], bus.ByteIn};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_full) begin
                mem_address <= {{(DATA_WIDTH-LEN_WIDTH-2){1'b0}}, word_idx, 2'b00};
                mem_data    <= {assy, bus.ByteIn};
            end
            if ((state == S_WRITE) && !bus.Abort && !last_word)
                word_idx <= word_idx + ONE_L;
        end
    end

    assign bus.MemAddress   = mem_address;
    assign bus.MemWriteData = mem_data;
    assign bus.Error        = error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench: length-check vector table, randomized loads checked
// against a word-list model, and hand sequences for latency, abort and reset.
module tb_program_loader;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [5:0] wc;
        logic       exp_busy;
        logic       exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    program_loader_if bus ();
    program_loader dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int done_cnt, done_cyc, last_wr_cyc, hold_fall_cyc, rdy_in_write;
    logic prev_hold = 1'b0;

    always @(negedge clk) begin
        if (bus.MemWrite === 1'b1) begin
            wr_addr.push_back(bus.MemAddress);
            wr_data.push_back(bus.MemWriteData);
            last_wr_cyc = cyc;
            if (bus.ByteReady !== 1'b0) rdy_in_write++;
        end
        if (bus.Done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (prev_hold && (bus.CpuHold === 1'b0)) hold_fall_cyc = cyc;
        prev_hold = (bus.CpuHold === 1'b1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt      = 0;
        done_cyc      = -1;
        last_wr_cyc   = -1;
        hold_fall_cyc = -1;
        rdy_in_write  = 0;
    endtask

    task automatic send_start(input logic [5:0] wc);
        bus.Start     = 1'b1;
        bus.WordCount = wc;
        step();
        bus.Start     = 1'b0;
    endtask

    // Presents n bytes, inserting idle cycles with probability gap_pct%.
    task automatic feed(input bq_t b, input int n, input int gap_pct, input bit inj_start);
        int  i;
        int  guard;
        bit  v;
        logic rdy;
        i = 0;
        guard = 0;
        while (i < n && guard < 4000) begin
            v = ($urandom_range(99) >= gap_pct);
            bus.ByteValid = v;
            bus.ByteIn    = v ? b[i] : 8'($urandom);
            if (inj_start && i == 5) begin
                bus.Start     = 1'b1;
                bus.WordCount = 6'd1;
            end else begin
                bus.Start = 1'b0;
            end
            rdy = bus.ByteReady;
            step();
            if (v && rdy) i++;
            guard++;
        end
        bus.ByteValid = 1'b0;
        bus.Start     = 1'b0;
        chk("feed_timeout", 32'(i), 32'(n));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (bus.Busy !== 1'b0 && k < 50) begin
            step();
            k++;
        end
        chk("idle_timeout", 32'(bus.Busy), 32'd0);
    endtask

    task automatic load_and_verify(input bq_t b, input int wc, input int gap_pct, input bit inj_start);
        logic [31:0] exp_word;
        clear_mon();
        send_start(6'(wc));
        feed(b, 4 * wc, gap_pct, inj_start);
        wait_idle();
        step();
        chk("write_count", 32'(wr_addr.size()), 32'(wc));
        for (int w = 0; w < wc && w < wr_addr.size(); w++) begin
            exp_word = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
            chk($sformatf("addr[%0d]", w), wr_addr[w], 32'(4 * w));
            chk($sformatf("data[%0d]", w), wr_data[w], exp_word);
        end
        chk("done_count", 32'(done_cnt), 32'd1);
        chk("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
        chk("hold_fall_latency", 32'(hold_fall_cyc - last_wr_cyc), 32'd2);
        chk("ready_in_write", 32'(rdy_in_write), 32'd0);
        chk("error_after_load", 32'(bus.Error), 32'd0);
    endtask

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    vec_t vt[6];
    bq_t  bytes;
    int   wc;

    initial begin
        reset         = 1'b0;
        bus.Start     = 1'b0;
        bus.Abort     = 1'b0;
        bus.WordCount = '0;
        bus.ByteIn    = '0;
        bus.ByteValid = 1'b0;
        clear_mon();
        #3;
        chk("rst_ready",  32'(bus.ByteReady), 32'd0);
        chk("rst_write",  32'(bus.MemWrite), 32'd0);
        chk("rst_addr",   bus.MemAddress, 32'd0);
        chk("rst_data",   bus.MemWriteData, 32'd0);
        chk("rst_hold",   32'(bus.CpuHold), 32'd0);
        chk("rst_busy",   32'(bus.Busy), 32'd0);
        chk("rst_done",   32'(bus.Done), 32'd0);
        chk("rst_error",  32'(bus.Error), 32'd0);
        step();
        reset = 1'b1;
        step();

        // Length check table; accepted loads are aborted straight away.
        vt[0] = '{6'd0,  1'b0, 1'b1};
        vt[1] = '{6'd33, 1'b0, 1'b1};
        vt[2] = '{6'd63, 1'b0, 1'b1};
        vt[3] = '{6'd2,  1'b1, 1'b0};
        vt[4] = '{6'd32, 1'b1, 1'b0};
        vt[5] = '{6'd1,  1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            send_start(vt[i].wc);
            chk($sformatf("vec%0d_busy", i),  32'(bus.Busy),    32'(vt[i].exp_busy));
            chk($sformatf("vec%0d_hold", i),  32'(bus.CpuHold), 32'(vt[i].exp_busy));
            chk($sformatf("vec%0d_error", i), 32'(bus.Error),   32'(vt[i].exp_err));
            if (vt[i].exp_busy) begin
                bus.Abort = 1'b1;
                step();
                bus.Abort = 1'b0;
                chk($sformatf("vec%0d_abort_busy", i),  32'(bus.Busy),  32'd0);
                chk($sformatf("vec%0d_abort_error", i), 32'(bus.Error), 32'd1);
            end
        end

        // Single word, back-to-back bytes, exact cycle latency.
        clear_mon();
        bytes = '{8'h20, 8'h08, 8'h00, 8'h05};
        send_start(6'd1);
        chk("single_error_cleared", 32'(bus.Error), 32'd0);
        feed(bytes, 4, 0, 1'b0);
        chk("single_memwrite", 32'(bus.MemWrite), 32'd1);
        chk("single_addr", bus.MemAddress, 32'h0);
        chk("single_data", bus.MemWriteData, 32'h20080005);
        chk("single_ready_low", 32'(bus.ByteReady), 32'd0);
        step();
        chk("single_done", 32'(bus.Done), 32'd1);
        chk("single_hold_in_done", 32'(bus.CpuHold), 32'd1);
        step();
        chk("single_hold_off", 32'(bus.CpuHold), 32'd0);
        chk("single_done_off", 32'(bus.Done), 32'd0);
        chk("single_busy_off", 32'(bus.Busy), 32'd0);
        chk("single_addr_kept", bus.MemAddress, 32'h0);
        chk("single_data_kept", bus.MemWriteData, 32'h20080005);

        // Backpressure: a byte offered every cycle across WRITE cycles.
        load_and_verify(rand_bytes(16), 4, 0, 1'b0);

        // Abort after six bytes of a two-word load.
        clear_mon();
        bytes = rand_bytes(8);
        send_start(6'd2);
        feed(bytes, 6, 0, 1'b0);
        bus.Abort = 1'b1;
        step();
        bus.Abort = 1'b0;
        chk("abort_busy", 32'(bus.Busy), 32'd0);
        chk("abort_hold", 32'(bus.CpuHold), 32'd0);
        chk("abort_error", 32'(bus.Error), 32'd1);
        repeat (3) step();
        chk("abort_writes", 32'(wr_addr.size()), 32'd1);
        if (wr_addr.size() > 0) begin
            chk("abort_addr0", wr_addr[0], 32'h0);
            chk("abort_data0", wr_data[0], {bytes[0], bytes[1], bytes[2], bytes[3]});
        end
        chk("abort_no_done", 32'(done_cnt), 32'd0);

        // Randomized loads with gaps; some with a Start injected while busy.
        for (int r = 0; r < 8; r++) begin
            wc = $urandom_range(1, 8);
            load_and_verify(rand_bytes(4 * wc), wc, $urandom_range(0, 60), r[0]);
        end

        // Full-depth load reaches the top address.
        load_and_verify(rand_bytes(128), 32, 20, 1'b0);

        // Asynchronous reset mid-load.
        clear_mon();
        send_start(6'd4);
        feed(rand_bytes(16), 5, 0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.ByteReady), 32'd0);
        chk("arst_write", 32'(bus.MemWrite), 32'd0);
        chk("arst_addr",  bus.MemAddress, 32'd0);
        chk("arst_data",  bus.MemWriteData, 32'd0);
        chk("arst_hold",  32'(bus.CpuHold), 32'd0);
        chk("arst_busy",  32'(bus.Busy), 32'd0);
        chk("arst_done",  32'(bus.Done), 32'd0);
        chk("arst_error", 32'(bus.Error), 32'd0);
        step();
        reset = 1'b1;
        step();
        load_and_verify(rand_bytes(8), 2, 10, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
